// File: rtl/cr16_ctrl_fsm.sv
// cr16_ctrl_fsm: multicycle main control unit for the CR16 datapath.
// Fetches an instruction over a req/ack handshake, decodes it and then sequences
// the ALU, register-file, memory and PC strobes. It also produces ALUop and
// OPCodeExtention for the downstream ALU control decoder.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   instr[15:0]        memory read data (instruction word)
//   mem_ack            memory completion, may coincide with mem_req
//   flags[4:0]         PSR flags {C,L,F,Z,N}
//   ALUop[2:0]         ALU operation class for the ALU control decoder
//   OPCodeExtention    IR[7:4] for R-type and shift ops, else 0
//   alu_src_b          0 = Rsrc, 1 = immediate
//   imm_mode[1:0]      00 sext, 01 zext, 10 <<8
//   ir_we, pc_we       instruction / program counter write enables
//   reg_we, flags_we   register file / PSR write enables
//   pc_src[1:0]        00 PC+1, 01 PC+disp, 10 Rtarget
//   wb_sel             0 = ALU, 1 = memory
//   mem_req, mem_we    memory strobes
//   addr_sel           0 = PC, 1 = Raddr
//   state[2:0]         debug view of the current state
//   fault              sticky error flag
module cr16_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ack,
  input  logic [4:0]  flags,
  output logic [2:0]  ALUop,
  output logic [3:0]  OPCodeExtention,
  output logic        alu_src_b,
  output logic [1:0]  imm_mode,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        flags_we,
  output logic [1:0]  pc_src,
  output logic        wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [2:0]  state,
  output logic        fault
);

  // Counter only needs to reach MEM_TIMEOUT-1; the next un-acked cycle faults.
  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StBranch = 3'd4,
    StHalt   = 3'd7
  } state_e;

  state_e          r_state, w_state_d;
  logic [15:4]     r_ir;
  logic [2:0]      r_aluop;
  logic [3:0]      r_ext;
  logic            r_srcb;
  logic [1:0]      r_imm;
  logic            r_no_wb, r_is_load, r_is_stor, r_is_jcond;
  logic            r_fault;
  logic [CntW-1:0] r_tmo, w_tmo_d;

  state_e          w_dec_state;
  logic [2:0]      w_dec_aluop;
  logic [3:0]      w_dec_ext;
  logic            w_dec_srcb;
  logic [1:0]      w_dec_imm;
  logic            w_dec_no_wb, w_dec_load, w_dec_stor, w_dec_jcond;
  logic            w_cond, w_mem_req, w_tmo_hit, w_moore_en;
  logic            w_unused_instr;

  // Low instruction bits (registers, displacement) are consumed by the datapath IR.
  assign w_unused_instr = ^instr[3:0];

  // Decode of the latched instruction; results are registered on DECODE exit.
  always_comb begin
    w_dec_state = StExec;
    w_dec_aluop = 3'b000;
    w_dec_imm   = 2'b00;
    w_dec_srcb  = 1'b1;
    w_dec_no_wb = 1'b0;
    w_dec_load  = 1'b0;
    w_dec_stor  = 1'b0;
    w_dec_jcond = 1'b0;
    unique case (r_ir[15:12])
      4'b0000: begin
        w_dec_srcb  = 1'b0;
        w_dec_no_wb = (r_ir[7:4] == 4'b1011);  // CMP
      end
      4'b0101: w_dec_aluop = 3'b001;
      4'b1001: w_dec_aluop = 3'b010;
      4'b1011: begin
        w_dec_aluop = 3'b010;
        w_dec_no_wb = 1'b1;                   // CMPI
      end
      4'b0001: begin w_dec_aluop = 3'b011; w_dec_imm = 2'b01; end
      4'b0010: begin w_dec_aluop = 3'b100; w_dec_imm = 2'b01; end
      4'b0011: begin w_dec_aluop = 3'b101; w_dec_imm = 2'b01; end
      4'b1101: begin w_dec_aluop = 3'b110; w_dec_imm = 2'b01; end
      4'b1111: begin w_dec_aluop = 3'b110; w_dec_imm = 2'b10; end
      4'b1000: w_dec_aluop = 3'b111;
      4'b0100: begin
        w_dec_srcb = 1'b0;
        unique case (r_ir[7:4])
          4'b0000: begin w_dec_state = StMem;    w_dec_load  = 1'b1; end
          4'b0100: begin w_dec_state = StMem;    w_dec_stor  = 1'b1; end
          4'b1100: begin w_dec_state = StBranch; w_dec_jcond = 1'b1; end
          default: w_dec_state = StHalt;
        endcase
      end
      4'b1100: begin w_dec_state = StBranch; w_dec_srcb = 1'b0; end
      default: begin w_dec_state = StHalt; w_dec_srcb = 1'b0; end
    endcase
    w_dec_ext = (w_dec_aluop == 3'b000 || w_dec_aluop == 3'b111) ? r_ir[7:4] : 4'b0000;
  end

  // Branch condition, flags = {C,L,F,Z,N}.
  always_comb begin
    w_cond = 1'b0;
    unique case (r_ir[11:8])
      4'h0: w_cond = flags[1];
      4'h1: w_cond = ~flags[1];
      4'h2: w_cond = flags[4];
      4'h3: w_cond = ~flags[4];
      4'h4: w_cond = flags[3];
      4'h5: w_cond = ~flags[3];
      4'h6: w_cond = flags[0];
      4'h7: w_cond = ~flags[0];
      4'h8: w_cond = flags[2];
      4'h9: w_cond = ~flags[2];
      4'hA: w_cond = ~flags[3] & ~flags[1];
      4'hB: w_cond = flags[3] | flags[1];
      4'hC: w_cond = ~flags[0] & ~flags[1];
      4'hD: w_cond = flags[0] | flags[1];
      4'hE: w_cond = 1'b1;
      4'hF: w_cond = 1'b0;
    endcase
  end

  assign w_mem_req = (r_state == StFetch) || (r_state == StMem);
  assign w_tmo_hit = w_mem_req & ~mem_ack & (r_tmo == TmoLast);

  // Next state and strobes.
  always_comb begin
    w_state_d = r_state;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    flags_we  = 1'b0;
    pc_src    = 2'b00;
    wb_sel    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    unique case (r_state)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          w_state_d = StDecode;
        end
      end
      StDecode: w_state_d = w_dec_state;
      StExec: begin
        flags_we  = 1'b1;
        reg_we    = ~r_no_wb;
        w_state_d = StFetch;
      end
      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = r_is_stor;
        if (mem_ack) begin
          reg_we    = r_is_load;
          wb_sel    = r_is_load;
          w_state_d = StFetch;
        end
      end
      StBranch: begin
        if (w_cond) begin
          pc_we  = 1'b1;
          pc_src = r_is_jcond ? 2'b10 : 2'b01;
        end
        w_state_d = StFetch;
      end
      StHalt: w_state_d = StHalt;
      default: w_state_d = StHalt;
    endcase
    if (w_tmo_hit) begin
      w_state_d = StHalt;
    end
    // Reset abandons any transaction in the same cycle.
    if (reset) begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
      flags_we = 1'b0;
      pc_src   = 2'b00;
      wb_sel   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
    end
  end

  always_comb begin
    w_tmo_d = r_tmo;
    if (mem_ack || (w_state_d != r_state)) begin
      w_tmo_d = '0;
    end else if (w_mem_req) begin
      w_tmo_d = r_tmo + 1'b1;
    end
  end

  // Decode fields are only visible while the decoded instruction executes.
  assign w_moore_en      = ~reset &
                           ((r_state == StExec) || (r_state == StMem) || (r_state == StBranch));
  assign ALUop           = w_moore_en ? r_aluop : 3'b000;
  assign OPCodeExtention = w_moore_en ? r_ext   : 4'b0000;
  assign alu_src_b       = w_moore_en & r_srcb;
  assign imm_mode        = w_moore_en ? r_imm   : 2'b00;
  assign state           = reset ? 3'b000 : r_state;
  assign fault           = r_fault & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StFetch;
      r_ir       <= '0;
      r_aluop    <= '0;
      r_ext      <= '0;
      r_srcb     <= 1'b0;
      r_imm      <= '0;
      r_no_wb    <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_stor  <= 1'b0;
      r_is_jcond <= 1'b0;
      r_fault    <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_state <= w_state_d;
      r_tmo   <= w_tmo_d;
      if (ir_we) begin
        r_ir <= instr[15:4];
      end
      if (r_state == StDecode) begin
        r_aluop    <= w_dec_aluop;
        r_ext      <= w_dec_ext;
        r_srcb     <= w_dec_srcb;
        r_imm      <= w_dec_imm;
        r_no_wb    <= w_dec_no_wb;
        r_is_load  <= w_dec_load;
        r_is_stor  <= w_dec_stor;
        r_is_jcond <= w_dec_jcond;
      end
      if (w_state_d == StHalt) begin
        r_fault <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cr16_ctrl_fsm.md
# cr16_ctrl_fsm

Multicycle main control unit for the CR16 datapath. Fetches a 16-bit instruction over a req/ack memory handshake, decodes it, and sequences ALU, register-file, memory and PC strobes. It is the producing end of the ALU control interface: it encodes `ALUop` and `OPCodeExtention` for the downstream ALUctrl decoder. It sits between instruction/data memory and the datapath register enables.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum consecutive un-acked `mem_req` cycles before a fault.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in 16: memory read data, captured into IR by the datapath on `ir_we`.
- `mem_ack` in 1: memory completion; may be high in the same cycle as `mem_req`.
- `flags` in 5: {C,L,F,Z,N} from the PSR.
- `ALUop` out 3: 000 R-type (use ext), 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 pass-B, 111 shift.
- `OPCodeExtention` out 4: IR[7:4] when `ALUop` is 000 or 111, else 0000.
- `alu_src_b` out 1: 0 = Rsrc, 1 = immediate.
- `imm_mode` out 2: 00 sign-extend IR[7:0], 01 zero-extend, 10 IR[7:0]<<8.
- `ir_we`, `pc_we`, `reg_we`, `flags_we` out 1 each: register enables.
- `pc_src` out 2: 00 PC+1, 01 PC+sext(disp), 10 Rtarget.
- `wb_sel` out 1: 0 = ALU, 1 = memory.
- `mem_req`, `mem_we` out 1 each: memory strobes.
- `addr_sel` out 1: 0 = PC, 1 = Raddr.
- `state` out 3: debug view of the current state.
- `fault` out 1: sticky error flag.

## Operation
States: FETCH=0, DECODE=1, EXEC=2, MEM=3, BRANCH=4, HALT=7.
- FETCH: `mem_req`=1, `addr_sel`=0.
  - On `mem_ack`: `ir_we`=1, `pc_we`=1, `pc_src`=00, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no strobes. Routing by IR[15:12]:
  - 0000 R-type → EXEC.
  - I-type → EXEC with `ALUop`/`imm_mode` as follows: 0101 ADDI 001/00; 1001 SUBI 010/00; 1011 CMPI 010/00; 0001 ANDI 011/01; 0010 ORI 100/01; 0011 XORI 101/01; 1101 MOVI 110/01; 1111 LUI 110/10; 1000 shift-immediate 111/00.
  - 0100 with IR[7:4]=0000 (LOAD) or 0100 (STOR) → MEM.
  - 0100 with IR[7:4]=1100 (Jcond) → BRANCH.
  - 1100 (Bcond) → BRANCH.
  - Any other opcode or extension → HALT, `fault` set.
- EXEC: one cycle.
  - `flags_we`=1.
  - `reg_we`=1, except for CMPI and R-type extension 1011 (CMP), where `reg_we`=0.
  - `alu_src_b`=0 for R-type, 1 otherwise.
  - → FETCH.
- MEM: `mem_req`=1, `addr_sel`=1.
  - STOR: `mem_we`=1.
  - LOAD: on `mem_ack`, `reg_we`=1 and `wb_sel`=1.
  - → FETCH on `mem_ack`.
- BRANCH: one cycle.
  - Condition code is IR[11:8]: EQ Z; NE !Z; CS C; CC !C; HI L; LS !L; GT N; LE !N; FS F; FC !F; LO !L&!Z; HS L|Z; LT !N&!Z; GE N|Z; UC 1; 1111 never.
  - If the condition is true: `pc_we`=1, `pc_src`=01 for Bcond, 10 for Jcond.
  - → FETCH.
- HALT: `fault`=1, all strobes low; left only by `reset`.
- Timeout: a counter increments on each cycle with `mem_req`=1 and `mem_ack`=0, and clears on ack or state change. If it reaches `MEM_TIMEOUT` → HALT, `fault`=1.

## Timing
- Reset (synchronous): the next edge enters FETCH.
  - Cleared: `fault`, the timeout counter, and the latched decode fields.
  - During reset, all strobes are 0, `ALUop`=000, `OPCodeExtention`=0000, `pc_src`=00, `imm_mode`=00, `state`=0.
- Reset mid-MEM or mid-FETCH: the transaction is abandoned; no `reg_we` or `mem_we` is issued in the reset cycle.
- `ALUop`, `OPCodeExtention`, `alu_src_b` and `imm_mode` are Moore outputs, registered from IR at the DECODE→next transition. They hold through EXEC, MEM and BRANCH, and are 0 in FETCH and HALT.
- `ir_we`, `pc_we` in FETCH, and the LOAD `reg_we` are Mealy on `mem_ack`, valid in the ack cycle.
- Latency with zero-wait ack:
  - ALU op: 3 cycles.
  - Branch: 3 cycles.
  - Load/store: 4 cycles.
  - Each wait cycle adds 1.
- `mem_we` is held for the whole MEM stay, until ack.

## Test plan
- Reset held 2 cycles, then `instr`=0x0152 (ADD R1,R2; ext 0101) with ack tied high.
  - `state` goes 0→1→2.
  - EXEC shows `ALUop`=000, `OPCodeExtention`=0101, `reg_we`=1, `flags_we`=1, `alu_src_b`=0.
  - Back in FETCH on cycle 4.
- `instr`=0xB3FF (CMPI), ack delayed 2 cycles in FETCH.
  - `ir_we` is high only in the ack cycle.
  - EXEC shows `ALUop`=010, `imm_mode`=00, `reg_we`=0, `flags_we`=1.
- LOAD 0x4102, ack delayed 3 cycles in MEM.
  - `mem_req` and `addr_sel` stay 1 for 4 cycles.
  - `reg_we`=1 and `wb_sel`=1 only on the ack cycle.
  - Repeat as STOR 0x4142: `mem_we` held 4 cycles, `reg_we` never asserted.
- BEQ 0xC005 with Z=1: `pc_we`=1, `pc_src`=01. With Z=0: `pc_we`=0. Repeat as JUC 0x4EC3: `pc_src`=10.
- Illegal 0x6000: after DECODE, `state`=7 and `fault`=1, held through 20 further cycles until `reset`.
- `mem_ack` held 0 in FETCH: HALT entered exactly after `MEM_TIMEOUT` un-acked cycles. Separately, `reset` asserted mid-MEM: no `reg_we` or `mem_we` in the reset cycle, FETCH on the next edge.
